// File: rtl/telem_pkg.sv
// Shared types and defaults for the telemetry packet receiver.
package telem_pkg;

  typedef enum logic [1:0] {SYNC1, SYNC2, HI, LO} telem_st_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;

  localparam logic [7:0] DELIM1_DEF = 8'hAA;
  localparam logic [7:0] DELIM2_DEF = 8'h55;

  // Bits of the high byte above the channel MSB; empty when CH_W is 16.
  function automatic logic [7:0] pad_mask(input int ch_w);
    logic [7:0] m;
    m = 8'hFF;
    m = m << (ch_w - 8);
    return m;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: start-bit re-check at mid-bit, LSB first, stop-bit check.
module uart_rx_byte
  import telem_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       stop_err
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);

  logic          rx_s1, rx_s2, rx_d;
  logic [1:0]    live;
  rx_st_t        st, st_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    shreg, sh_nxt;

  // rx_d only reflects the real line once the synchroniser has flushed its
  // reset value, so a line held low across reset is not taken as a start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_d    <= 1'b0;
      live    <= 2'b00;
      st      <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      rx_s1   <= RX;
      rx_s2   <= rx_s1;
      rx_d    <= rx_s2 & live[1];
      live    <= {live[0], 1'b1};
      st      <= st_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shreg   <= sh_nxt;
    end
  end

  always_comb begin
    st_nxt   = st;
    cnt_nxt  = (cnt != '0) ? cnt - 1'b1 : cnt;
    bit_nxt  = bit_idx;
    sh_nxt   = shreg;
    rdy      = 1'b0;
    stop_err = 1'b0;
    case (st)
      RX_IDLE: if (rx_d && !rx_s2) begin
        st_nxt  = RX_START;
        cnt_nxt = HALF;
      end
      RX_START: if (cnt == '0) begin
        if (rx_s2) st_nxt = RX_IDLE;
        else begin
          st_nxt  = RX_DATA;
          cnt_nxt = FULL;
          bit_nxt = '0;
        end
      end
      RX_DATA: if (cnt == '0) begin
        sh_nxt  = {rx_s2, shreg[7:1]};
        cnt_nxt = FULL;
        bit_nxt = bit_idx + 3'd1;
        if (bit_idx == 3'd7) st_nxt = RX_STOP;
      end
      RX_STOP: if (cnt == '0) begin
        st_nxt   = RX_IDLE;
        rdy      = rx_s2;
        stop_err = ~rx_s2;
      end
      default: st_nxt = RX_IDLE;
    endcase
  end

  assign rx_data = shreg;

endmodule

// File: rtl/telem_pkt_rcv.sv
// Telemetry packet receiver: delimiter sync, channel unpacking into a shadow
// register, atomic update of ch_data, and framing/pad/timeout error counting.
module telem_pkt_rcv
  import telem_pkg::*;
#(
  parameter int         BAUD_DIV = 2604,
  parameter int         NUM_CH   = 3,
  parameter int         CH_W     = 12,
  parameter logic [7:0] DELIM1   = DELIM1_DEF,
  parameter logic [7:0] DELIM2   = DELIM2_DEF,
  parameter int         TO_BITS  = 40
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   RX,
  output logic [NUM_CH*CH_W-1:0] ch_data,
  output logic                   vld,
  output logic                   frm_err,
  output logic [7:0]             err_cnt
);

  localparam int         TO_CYC = TO_BITS * BAUD_DIV;
  localparam int         TW     = $clog2(TO_CYC + 1);
  localparam int         CIW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int         DW     = NUM_CH * CH_W;
  localparam logic [7:0] PAD    = pad_mask(CH_W);

  logic [7:0]    rx_data;
  logic          rdy, stop_err;
  telem_st_t     st, st_nxt;
  logic [CIW-1:0] ch, ch_nxt;
  logic [DW-1:0] shadow, shadow_nxt;
  logic [TW-1:0] tmr;
  logic          err, commit, timed, expire;

  uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .RX       (RX),
    .rx_data  (rx_data),
    .rdy      (rdy),
    .stop_err (stop_err)
  );

  always_comb begin
    st_nxt     = st;
    ch_nxt     = ch;
    shadow_nxt = shadow;
    err        = 1'b0;
    commit     = 1'b0;
    timed      = (st != SYNC1);
    expire     = timed && (tmr == '0) && !rdy;
    if (stop_err || expire) err = 1'b1;
    else if (rdy) begin
      case (st)
        SYNC1: if (rx_data == DELIM1) st_nxt = SYNC2;
        SYNC2: begin
          if (rx_data == DELIM2) begin
            st_nxt = HI;
            ch_nxt = '0;
          end else if (rx_data != DELIM1) st_nxt = SYNC1;
        end
        HI: begin
          if ((rx_data & PAD) != 8'h00) err = 1'b1;
          else begin
            shadow_nxt[ch*CH_W+8 +: CH_W-8] = rx_data[CH_W-9:0];
            st_nxt = LO;
          end
        end
        LO: begin
          shadow_nxt[ch*CH_W +: 8] = rx_data;
          if (ch == CIW'(NUM_CH - 1)) begin
            commit = 1'b1;
            st_nxt = SYNC1;
          end else begin
            ch_nxt = ch + 1'b1;
            st_nxt = HI;
          end
        end
        default: st_nxt = SYNC1;
      endcase
    end
    if (err) begin
      st_nxt     = SYNC1;
      shadow_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st      <= SYNC1;
      ch      <= '0;
      shadow  <= '0;
      tmr     <= '0;
      ch_data <= '0;
      vld     <= 1'b0;
      frm_err <= 1'b0;
      err_cnt <= 8'h00;
    end else begin
      st      <= st_nxt;
      ch      <= ch_nxt;
      shadow  <= shadow_nxt;
      vld     <= commit;
      frm_err <= err;
      if (commit) ch_data <= shadow_nxt;
      // A byte arriving on the expiry cycle reloads the timer and wins.
      if (rdy) tmr <= TW'(TO_CYC - 1);
      else if (timed && tmr != '0) tmr <= tmr - 1'b1;
      if (err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
    end
  end

endmodule

// File: tb/tb_telem_pkt_rcv.sv
// Self-checking bench: directed vector table, reset/glitch sequences, a
// 4x16 configuration, and randomized packets against a packet-level model.
module tb_telem_pkt_rcv;

  localparam int BD = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_a = 1'b1;
  logic        rx_b = 1'b1;
  logic [35:0] data_a;
  logic        vld_a, ferr_a;
  logic [7:0]  ecnt_a;
  logic [63:0] data_b;
  logic        vld_b, ferr_b;
  logic [7:0]  ecnt_b;

  always #5 clk = ~clk;

  telem_pkt_rcv #(.BAUD_DIV(BD), .NUM_CH(3), .CH_W(12), .DELIM1(8'hAA),
                  .DELIM2(8'h55), .TO_BITS(40)) dut_a (
    .clk(clk), .rst_n(rst_n), .RX(rx_a), .ch_data(data_a),
    .vld(vld_a), .frm_err(ferr_a), .err_cnt(ecnt_a));

  telem_pkt_rcv #(.BAUD_DIV(BD), .NUM_CH(4), .CH_W(16), .DELIM1(8'hAA),
                  .DELIM2(8'h55), .TO_BITS(40)) dut_b (
    .clk(clk), .rst_n(rst_n), .RX(rx_b), .ch_data(data_b),
    .vld(vld_b), .frm_err(ferr_b), .err_cnt(ecnt_b));

  int errors = 0;
  int checks = 0;
  int nvld_a = 0, nerr_a = 0, nvld_b = 0, nerr_b = 0;

  always @(negedge clk) begin
    if (vld_a)  nvld_a++;
    if (ferr_a) nerr_a++;
    if (vld_b)  nvld_b++;
    if (ferr_b) nerr_b++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_rx(input int which, input logic v);
    if (which == 0) rx_a = v;
    else rx_b = v;
  endtask

  // One 8N1 frame followed by at least one idle bit plus gap_bits more.
  task automatic send_byte(input int which, input logic [7:0] b, input logic stop,
                           input int gap_bits);
    set_rx(which, 1'b0);
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_rx(which, b[i]);
      repeat (BD) @(negedge clk);
    end
    set_rx(which, stop);
    repeat (BD) @(negedge clk);
    set_rx(which, 1'b1);
    repeat ((gap_bits + 1) * BD) @(negedge clk);
  endtask

  typedef struct {
    logic [79:0] seq;      // bytes in send order, first byte most significant
    int          n;
    int          bad_stop;
    int          gap_idx;
    int          gap_bits;
    int          exp_vld;
    int          exp_err;
    logic [35:0] exp_data;
    logic [7:0]  exp_ecnt;
  } vec_t;

  vec_t tv[7];

  task automatic run_vec(input vec_t v, input string tag);
    int v0, e0;
    v0 = nvld_a;
    e0 = nerr_a;
    for (int i = 0; i < v.n; i++)
      send_byte(0, v.seq[8*(v.n-1-i) +: 8], (i != v.bad_stop),
                (i == v.gap_idx) ? v.gap_bits : 0);
    repeat (2 * BD) @(negedge clk);
    check({tag, " vld"},     64'(nvld_a - v0), 64'(v.exp_vld));
    check({tag, " frm_err"}, 64'(nerr_a - e0), 64'(v.exp_err));
    check({tag, " ch_data"}, 64'(data_a), 64'(v.exp_data));
    check({tag, " err_cnt"}, 64'(ecnt_a), 64'(v.exp_ecnt));
  endtask

  initial begin
    vec_t        v;
    logic [7:0]  q[$];
    logic [11:0] c[3];
    logic [35:0] m_data;
    int          m_ecnt, kind, njunk, k, v0, e0, bad_idx, gap_idx, exp_v, exp_e;

    tv[0] = '{80'hAA550B1102340700, 8, -1, -1, 0, 1, 0, 36'h700234B11, 8'd0};
    tv[1] = '{80'hAA551B1102340700, 8, -1, -1, 0, 0, 1, 36'h700234B11, 8'd1};
    tv[2] = '{80'hAA550FFF00000123, 8, -1, -1, 0, 1, 0, 36'h123000FFF, 8'd1};
    tv[3] = '{80'h00AAAA550ABC0DEF0102, 10, -1, -1, 0, 1, 0, 36'h102DEFABC, 8'd1};
    tv[4] = '{80'hAA550B, 3, -1, 2, 41, 0, 1, 36'h102DEFABC, 8'd2};
    tv[5] = '{80'hAA55000100020003, 8, -1, -1, 0, 1, 0, 36'h003002001, 8'd2};
    tv[6] = '{80'hAA550B1102340700, 8, 4, -1, 0, 0, 1, 36'h003002001, 8'd3};

    repeat (4) @(negedge clk);
    check("reset ch_data", 64'(data_a), 64'h0);
    check("reset vld",     64'(vld_a), 64'h0);
    check("reset frm_err", 64'(ferr_a), 64'h0);
    check("reset err_cnt", 64'(ecnt_a), 64'h0);
    rst_n = 1'b1;
    repeat (4 * BD) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(tv[i], $sformatf("vec%0d", i));

    // Short low pulse: rejected at the mid-bit start re-check, no error.
    rx_a = 1'b0;
    repeat (2) @(negedge clk);
    rx_a = 1'b1;
    repeat (2 * BD) @(negedge clk);
    v = tv[0];
    v.exp_ecnt = 8'd3;
    run_vec(v, "glitch");

    // Reset in the middle of a byte, line held low across the release.
    rx_a = 1'b0;
    repeat (3 * BD) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst ch_data", 64'(data_a), 64'h0);
    check("midrst err_cnt", 64'(ecnt_a), 64'h0);
    check("midrst vld",     64'(vld_a), 64'h0);
    check("midrst frm_err", 64'(ferr_a), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * BD) @(negedge clk);
    rx_a = 1'b1;
    repeat (2 * BD) @(negedge clk);
    v = tv[2];
    v.exp_ecnt = 8'd0;
    run_vec(v, "postrst");

    // 4 channels of 16 bits: no pad bits exist.
    v0 = nvld_b;
    e0 = nerr_b;
    begin
      logic [79:0] s;
      s = 80'hAA55FFFF123400018000;
      for (int i = 0; i < 10; i++) send_byte(1, s[8*(9-i) +: 8], 1'b1, 0);
    end
    repeat (2 * BD) @(negedge clk);
    check("wide vld",     64'(nvld_b - v0), 64'd1);
    check("wide frm_err", 64'(nerr_b - e0), 64'd0);
    check("wide ch_data", data_b, 64'h8000_0001_1234_FFFF);
    check("wide err_cnt", 64'(ecnt_b), 64'd0);

    // Randomized packets; the model tracks only packet-level outcomes.
    m_data = 36'h123000FFF;
    m_ecnt = 0;
    for (int p = 0; p < 30; p++) begin
      q.delete();
      njunk = $urandom_range(0, 2);
      for (int j = 0; j < njunk; j++) begin
        logic [7:0] jb;
        jb = 8'($urandom_range(0, 255));
        if (jb == 8'hAA) jb = 8'h3C;
        q.push_back(jb);
      end
      q.push_back(8'hAA);
      q.push_back(8'h55);
      for (int i = 0; i < 3; i++) begin
        c[i] = 12'($urandom_range(0, 4095));
        q.push_back({4'h0, c[i][11:8]});
        q.push_back(c[i][7:0]);
      end
      kind = $urandom_range(0, 5);
      bad_idx = -1;
      gap_idx = -1;
      exp_v = 0;
      exp_e = 1;
      if (kind <= 2) begin
        exp_v = 1;
        exp_e = 0;
        for (int i = 0; i < 3; i++) m_data[12*i +: 12] = c[i];
      end else if (kind == 3) begin
        int ci;
        ci = $urandom_range(0, 2);
        k = njunk + 2 + 2 * ci;
        q[k] = {4'($urandom_range(1, 15)), c[ci][11:8]};
      end else if (kind == 4) begin
        k = $urandom_range(0, q.size() - 1);
        bad_idx = k;
      end else begin
        k = $urandom_range(njunk, q.size() - 2);
        gap_idx = k;
      end
      if (kind > 2) while (q.size() > k + 1) void'(q.pop_back());
      if (m_ecnt + exp_e > 255) m_ecnt = 255;
      else m_ecnt = m_ecnt + exp_e;

      v0 = nvld_a;
      e0 = nerr_a;
      for (int i = 0; i < q.size(); i++)
        send_byte(0, q[i], (i != bad_idx), (i == gap_idx) ? 41 : $urandom_range(0, 2));
      repeat (2 * BD) @(negedge clk);
      check($sformatf("rnd%0d k%0d vld", p, kind),     64'(nvld_a - v0), 64'(exp_v));
      check($sformatf("rnd%0d k%0d frm_err", p, kind), 64'(nerr_a - e0), 64'(exp_e));
      check($sformatf("rnd%0d k%0d ch_data", p, kind), 64'(data_a), 64'(m_data));
      check($sformatf("rnd%0d k%0d err_cnt", p, kind), 64'(ecnt_a), 64'(m_ecnt));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
